line_mem_responder: RTL and testbench
=====================================

// Module: line_mem_responder
// PURPOSE
//  Memory-side responder for the cache's line-refill/write-back port. Serves one 128-bit
//  line read (mem_r) or write (mem_w) at a time, returning a one-cycle mem_ready pulse after
//  a fixed programmable latency. Sits below the cache, in place of main memory, in the
//  lab SoC and in benches.
// PARAMETERS
//  LINE_ADDR_WIDTH  10   line-index bits; capacity = 2^LINE_ADDR_WIDTH lines of 128 bits
//  LATENCY          4    cycles from request acceptance to mem_ready; legal range 2..255
//  LINE_WIDTH       128  line width in bits; fixed, must equal the cache's line width
// PORTS
//  clk          in   1    single clock, all logic on posedge
//  rst          in   1    synchronous, active-high reset
//  mem_r        in   1    line read request, level, held by the cache until mem_ready
//  mem_w        in   1    line write request, level, held by the cache until mem_ready
//  mem_addr     in   32   byte address; [3:0] ignored; [LINE_ADDR_WIDTH+3:4] = line index
//  mem_w_data   in   128  write line, sampled at acceptance
//  mem_r_data   out  128  read line, registered, valid in the mem_ready cycle, held after it
//  mem_ready    out  1    one-cycle completion pulse, registered
//  busy         out  1    high in every state except IDLE
//  rd_cnt       out  32   completed reads, wraps at 2^32
//  wr_cnt       out  32   completed writes, wraps at 2^32
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; mem_ready=0; mem_r_data=0; busy=0; rd_cnt=0;
//    wr_cnt=0; latency counter=0. Line storage is NOT cleared.
//  - FSM states: IDLE, WAIT, RESP, GAP.
//    IDLE: if mem_w or mem_r is high in cycle T, latch the op, line index and mem_w_data.
//      Go to WAIT with cnt=LATENCY-1. If both are high, the write wins and the read
//      stays pending.
//    WAIT: cnt decrements each cycle. Go to RESP when cnt==1, so mem_ready is high in
//      exactly cycle T+LATENCY.
//    Abort: if the latched op's request input is low in any WAIT cycle, go to IDLE.
//      No storage write, no counter change, no mem_ready. This covers the 1-cycle
//      speculative mem_w the cache issues on a clean miss.
//    RESP: mem_ready=1 for this single cycle.
//      Write: the line is committed to storage at the end of RESP; wr_cnt increments.
//      Read: mem_r_data is loaded on entry to RESP from the storage read of the latched
//      index; rd_cnt increments.
//      Next state is GAP.
//    GAP: one turnaround cycle; requests are ignored. Next state is IDLE. The cache
//      deasserts its request in the mem_ready cycle, so the earliest next acceptance
//      is T+LATENCY+2.
//  - mem_addr and mem_w_data are not re-sampled after acceptance; later changes have no
//    effect.
//  - Read-after-write to the same line returns the new data when the read is accepted
//    at or after GAP.
//  - rst asserted mid-operation: the FSM returns to IDLE next cycle and no mem_ready is
//    issued. A write not yet in RESP is dropped; a write whose RESP edge coincides with
//    rst is dropped.
//  - Index wrap: address bits above LINE_ADDR_WIDTH+3 are ignored, so storage aliases
//    modulo capacity.
// STRUCTURE
//  - Shared package: FSM state encodings (2-bit), LINE_WIDTH=128, LINE_OFFSET_BITS=4.
//  - One sub-module: the existing bram (ADDR_WIDTH=LINE_ADDR_WIDTH, DATA_WIDTH=128).
//    raddr = latched index; waddr = latched index; we = RESP & op_is_write & ~rst.
//    Synchronous read, so LATENCY>=2 gives dout one cycle before capture.
// TESTING
//  1 LATENCY=4: write 0x...A5 to addr 0x40 at T=10 -> mem_ready only at T=14, wr_cnt=1;
//    a read of 0x4C accepted at T=16 returns 0x...A5 at T=20.
//  2 mem_w high for one cycle, then mem_r to the same address -> write aborted: no
//    mem_ready, wr_cnt=0; the read returns the previous contents after LATENCY.
//  3 mem_r and mem_w high together -> write served first (ready at T+4); read accepted at
//    T+6, ready at T+10 with the written data.
//  4 rst pulsed at T+2 of a write -> no mem_ready; line unchanged; counters 0.
//  5 LATENCY=2, addr 0x4000 with LINE_ADDR_WIDTH=10 -> aliases line 0; back-to-back
//    requests are spaced exactly 4 cycles apart.
//  6 mem_addr changed during WAIT -> the latched address is used; mem_r_data is held
//    after ready until the next read.

Source files
------------

// File: rtl/line_mem_responder_pkg.sv
// Shared types and constants for the line-memory responder.
// Combinational only: no latency, no backpressure.
package line_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int LINE_WIDTH       = 128;
    localparam int LINE_OFFSET_BITS = 4;

endpackage

// File: rtl/line_mem_responder_bram.sv
// Simple dual-port line store: one synchronous write port, one registered read port (read-old on collision).
// One cycle read latency, always accepts; contents are never reset.
module line_mem_responder_bram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
        dout <= mem[raddr];
    end

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder serving one 128-bit line read/write at a time; mem_ready pulses LATENCY cycles after acceptance.
// Requests are level-held by the cache; one GAP cycle follows each response and a dropped request aborts the op.
module line_mem_responder #(
    parameter int LINE_ADDR_WIDTH = 10,
    parameter int LATENCY         = 4,
    parameter int LINE_WIDTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_r,
    input  logic                  mem_w,
    input  logic [31:0]           mem_addr,
    input  logic [LINE_WIDTH-1:0] mem_w_data,
    output logic [LINE_WIDTH-1:0] mem_r_data,
    output logic                  mem_ready,
    output logic                  busy,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt
);

    import line_mem_responder_pkg::*;

    state_t                       state;
    state_t                       state_nxt;
    logic [7:0]                   cnt;
    logic [7:0]                   cnt_nxt;
    logic                         op_wr;
    logic [LINE_ADDR_WIDTH-1:0]   idx;
    logic [LINE_WIDTH-1:0]        wdata_q;
    logic [LINE_ADDR_WIDTH-1:0]   addr_idx;
    logic [LINE_ADDR_WIDTH-1:0]   raddr;
    logic [LINE_WIDTH-1:0]        rd_dout;
    logic                         op_req;
    logic                         accept;
    logic                         we;
    logic                         unused_addr_bits;

    assign addr_idx = mem_addr[LINE_ADDR_WIDTH+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
    assign unused_addr_bits = ^{mem_addr[31:LINE_ADDR_WIDTH+LINE_OFFSET_BITS],
                                mem_addr[LINE_OFFSET_BITS-1:0]};

    assign op_req = op_wr ? mem_w : mem_r;
    assign accept = (state == ST_IDLE) && (mem_w || mem_r);
    assign busy   = (state != ST_IDLE);

    // Feed the live index while idle so the read data is ready even at LATENCY=2.
    assign raddr = (state == ST_IDLE) ? addr_idx : idx;
    assign we    = (state == ST_RESP) && op_wr && !rst;

    line_mem_responder_bram #(
        .ADDR_WIDTH (LINE_ADDR_WIDTH),
        .DATA_WIDTH (LINE_WIDTH)
    ) u_bram (
        .clk   (clk),
        .we    (we),
        .waddr (idx),
        .din   (wdata_q),
        .raddr (raddr),
        .dout  (rd_dout)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (mem_w || mem_r) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = 8'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (!op_req) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 8'd0;
                end else if (cnt == 8'd1) begin
                    state_nxt = ST_RESP;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_RESP: state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            mem_ready  <= 1'b0;
            mem_r_data <= '0;
            rd_cnt     <= 32'd0;
            wr_cnt     <= 32'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_ready <= (state_nxt == ST_RESP);
            if (state_nxt == ST_RESP && !op_wr) begin
                mem_r_data <= rd_dout;
            end
            if (state == ST_RESP) begin
                if (op_wr) begin
                    wr_cnt <= wr_cnt + 32'd1;
                end else begin
                    rd_cnt <= rd_cnt + 32'd1;
                end
            end
        end
    end

    // Write wins a simultaneous request; the read stays pending at the port.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_wr   <= mem_w;
            idx     <= addr_idx;
            wdata_q <= mem_w_data;
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench: instance 0 has LATENCY=4, instance 1 has LATENCY=2 (both 10 index bits).
module tb_line_mem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_r      [2];
    logic         mem_w      [2];
    logic [31:0]  mem_addr   [2];
    logic [127:0] mem_w_data [2];
    logic [127:0] mem_r_data [2];
    logic         mem_ready  [2];
    logic         busy       [2];
    logic [31:0]  rd_cnt     [2];
    logic [31:0]  wr_cnt     [2];

    int cyc = 0;
    int rdy_n  [2] = '{0, 0};
    int rdy_at [2] = '{0, 0};
    int total = 0;
    int bad   = 0;

    localparam logic [127:0] D1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5;
    localparam logic [127:0] JUNK = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    localparam logic [127:0] D3   = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] D4   = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
    localparam logic [127:0] D6   = 128'h6666_0000_6666_0000_6666_0000_6666_0000;
    localparam logic [127:0] D7   = 128'h7777_ABCD_7777_ABCD_7777_ABCD_7777_ABCD;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_ready[i] === 1'b1) begin
                rdy_n[i]  = rdy_n[i] + 1;
                rdy_at[i] = cyc;
            end
        end
    end

    line_mem_responder #(.LINE_ADDR_WIDTH(10), .LATENCY(4), .LINE_WIDTH(128)) u4 (
        .clk(clk), .rst(rst), .mem_r(mem_r[0]), .mem_w(mem_w[0]), .mem_addr(mem_addr[0]),
        .mem_w_data(mem_w_data[0]), .mem_r_data(mem_r_data[0]), .mem_ready(mem_ready[0]),
        .busy(busy[0]), .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0])
    );

    line_mem_responder #(.LINE_ADDR_WIDTH(10), .LATENCY(2), .LINE_WIDTH(128)) u2 (
        .clk(clk), .rst(rst), .mem_r(mem_r[1]), .mem_w(mem_w[1]), .mem_addr(mem_addr[1]),
        .mem_w_data(mem_w_data[1]), .mem_r_data(mem_r_data[1]), .mem_ready(mem_ready[1]),
        .busy(busy[1]), .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1])
    );

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic w, input logic r,
                         input logic [31:0] a, input logic [127:0] wd);
        mem_w[d]      = w;
        mem_r[d]      = r;
        mem_addr[d]   = a;
        mem_w_data[d] = wd;
    endtask

    // Waits for the next mem_ready, drops the request in that cycle, then steps into GAP.
    task automatic wait_rdy(input int d, input logic drop_r, output int lat);
        int t0;
        int n0;
        t0  = cyc;
        n0  = rdy_n[d];
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (rdy_n[d] != n0) begin
                lat = rdy_at[d] - t0;
                mem_w[d] = 1'b0;
                if (drop_r) mem_r[d] = 1'b0;
                break;
            end
        end
        if (lat < 0) begin
            mem_w[d] = 1'b0;
            mem_r[d] = 1'b0;
        end
        step();
    endtask

    task automatic op(input int d, input logic w, input logic r, input logic [31:0] a,
                      input logic [127:0] wd, output int lat);
        step();
        drive(d, w, r, a, wd);
        wait_rdy(d, 1'b1, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int lat;
        int n;
        int g1;
        int g2;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, 32'h0, 128'h0);
        step();
        step();
        rst = 1'b0;

        chk("reset_ready", mem_ready[0], 0);
        chk("reset_busy", busy[0], 0);
        chk("reset_rd_cnt", rd_cnt[0], 0);
        chk("reset_wr_cnt", wr_cnt[0], 0);
        chk("reset_r_data", mem_r_data[0], 0);
        chk("reset_ready_l2", mem_ready[1], 0);

        // Write then read back through a different byte offset of the same line.
        n = rdy_n[0];
        op(0, 1'b1, 1'b0, 32'h40, D1, lat);
        chk("wr_latency", lat, 4);
        chk("wr_pulses", rdy_n[0] - n, 1);
        chk("wr_cnt_1", wr_cnt[0], 1);
        chk("busy_gap", busy[0], 1);
        op(0, 1'b0, 1'b1, 32'h4C, 128'h0, lat);
        chk("rd_latency", lat, 4);
        chk("rd_data", mem_r_data[0], D1);
        chk("rd_cnt_1", rd_cnt[0], 1);

        // One-cycle speculative write, then read of the same line.
        n = rdy_n[0];
        step();
        drive(0, 1'b1, 1'b0, 32'h40, JUNK);
        step();
        mem_w[0] = 1'b0;
        mem_r[0] = 1'b1;
        wait_rdy(0, 1'b1, lat);
        chk("abort_rd_latency", lat, 5);
        chk("abort_pulses", rdy_n[0] - n, 1);
        chk("abort_data", mem_r_data[0], D1);
        chk("abort_wr_cnt", wr_cnt[0], 1);
        chk("abort_rd_cnt", rd_cnt[0], 2);

        // Simultaneous read and write: write first, read accepted after GAP.
        step();
        drive(0, 1'b1, 1'b1, 32'h80, D3);
        wait_rdy(0, 1'b0, lat);
        chk("both_wr_latency", lat, 4);
        chk("both_wr_cnt", wr_cnt[0], 2);
        wait_rdy(0, 1'b1, lat);
        chk("both_rd_latency", lat, 5);
        chk("both_rd_data", mem_r_data[0], D3);
        chk("both_rd_cnt", rd_cnt[0], 3);

        // Reset two cycles into a write.
        step();
        drive(0, 1'b1, 1'b0, 32'h40, D4);
        step();
        step();
        rst = 1'b1;
        mem_w[0] = 1'b0;
        n = rdy_n[0];
        step();
        rst = 1'b0;
        chk("rst_busy", busy[0], 0);
        chk("rst_wr_cnt", wr_cnt[0], 0);
        chk("rst_rd_cnt", rd_cnt[0], 0);
        chk("rst_r_data", mem_r_data[0], 0);
        repeat (6) step();
        chk("rst_no_ready", rdy_n[0] - n, 0);
        op(0, 1'b0, 1'b1, 32'h40, 128'h0, lat);
        chk("rst_line_kept", mem_r_data[0], D1);
        chk("rst_rd_latency", lat, 4);

        // Reset coinciding with the RESP edge of a write.
        step();
        drive(0, 1'b1, 1'b0, 32'h40, D4);
        repeat (4) step();
        chk("resp_rst_ready", mem_ready[0], 1);
        rst = 1'b1;
        mem_w[0] = 1'b0;
        step();
        rst = 1'b0;
        chk("resp_rst_wr_cnt", wr_cnt[0], 0);
        op(0, 1'b0, 1'b1, 32'h40, 128'h0, lat);
        chk("resp_rst_line_kept", mem_r_data[0], D1);

        // Address changed during WAIT; read data held across a later write.
        step();
        drive(0, 1'b0, 1'b1, 32'h80, 128'h0);
        step();
        mem_addr[0] = 32'h40;
        wait_rdy(0, 1'b1, lat);
        chk("latched_addr_latency", lat, 3);
        chk("latched_addr_data", mem_r_data[0], D3);
        op(0, 1'b1, 1'b0, 32'hC0, D6, lat);
        chk("r_data_held", mem_r_data[0], D3);
        chk("held_wr_cnt", wr_cnt[0], 1);
        chk("held_rd_cnt", rd_cnt[0], 2);

        // LATENCY=2: index aliasing and back-to-back spacing.
        op(1, 1'b1, 1'b0, 32'h4000, D7, lat);
        chk("l2_wr_latency", lat, 2);
        g1 = cyc;
        op(1, 1'b0, 1'b1, 32'h0, 128'h0, lat);
        g2 = cyc;
        chk("l2_rd_latency", lat, 2);
        chk("l2_spacing", g2 - g1, 4);
        chk("l2_alias_data", mem_r_data[1], D7);
        chk("l2_counts", {rd_cnt[1], wr_cnt[1]}, {32'd1, 32'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
